// File: rtl/bp_rgmii_multi_link_pkg.sv
// Shared lane-state type, topology codes and the static routing helper
// for the multi-chip RGMII link model.
package bp_rgmii_multi_link_pkg;

    typedef enum logic [1:0] {e_idle, e_pass, e_drop} bp_rgmii_lane_state_e;

    localparam int unsigned e_topo_swap = 0;
    localparam int unsigned e_topo_ring = 1;

    // Which source lane feeds destination chip dst.
    function automatic int unsigned bp_rgmii_src_of(input int unsigned dst,
                                                    input int unsigned n,
                                                    input int unsigned topo);
        if (topo == e_topo_swap) begin
            return dst ^ 32'd1;
        end
        return (dst + n - 32'd1) % n;
    endfunction

endpackage

// File: rtl/bp_rgmii_link_lane.sv
// One RGMII link lane: frame-level enable gating, latency pipeline and
// saturating forwarded/dropped frame counters.
module bp_rgmii_link_lane
    import bp_rgmii_multi_link_pkg::*;
#(
    parameter int unsigned delay_p       = 1,
    parameter int unsigned count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [3:0]               tx_data_i,
    input  logic                     tx_ctl_i,
    input  logic                     link_en_i,
    output logic [3:0]               rx_data_o,
    output logic                     rx_ctl_o,
    output logic [count_width_p-1:0] frame_count_o,
    output logic [count_width_p-1:0] drop_count_o
);

    bp_rgmii_lane_state_e state, state_next;

    logic                           gate_ctl;
    logic [3:0]                     gate_data;
    logic                           frame_inc;
    logic                           drop_inc;
    logic [delay_p-1:0]             pipe_ctl;
    logic [delay_p-1:0][3:0]        pipe_data;
    logic [count_width_p-1:0]       frame_count;
    logic [count_width_p-1:0]       drop_count;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= e_idle;
        end else begin
            state <= state_next;
        end
    end

    // link_en_i matters only on the idle -> frame-start decision.
    always_comb begin
        state_next = state;
        case (state)
            e_idle:  if (tx_ctl_i) state_next = link_en_i ? e_pass : e_drop;
            e_pass:  if (!tx_ctl_i) state_next = e_idle;
            e_drop:  if (!tx_ctl_i) state_next = e_idle;
            default: state_next = e_idle;
        endcase
    end

    always_comb begin
        gate_ctl  = 1'b0;
        gate_data = 4'h0;
        frame_inc = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            e_idle: begin
                if (tx_ctl_i && link_en_i) begin
                    gate_ctl  = 1'b1;
                    gate_data = tx_data_i;
                end else if (tx_ctl_i) begin
                    drop_inc = 1'b1;
                end
            end
            e_pass: begin
                if (tx_ctl_i) begin
                    gate_ctl  = 1'b1;
                    gate_data = tx_data_i;
                end else begin
                    frame_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pipe_ctl  <= '0;
            pipe_data <= '0;
        end else begin
            pipe_ctl[0]  <= gate_ctl;
            pipe_data[0] <= gate_data;
            for (int i = 1; i < int'(delay_p); i++) begin
                pipe_ctl[i]  <= pipe_ctl[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (frame_inc && (frame_count != '1)) frame_count <= frame_count + 1'b1;
            if (drop_inc && (drop_count != '1)) drop_count <= drop_count + 1'b1;
        end
    end

    assign rx_ctl_o      = pipe_ctl[delay_p-1];
    assign rx_data_o     = pipe_data[delay_p-1];
    assign frame_count_o = frame_count;
    assign drop_count_o  = drop_count;

endmodule

// File: rtl/bp_rgmii_multi_link.sv
// Link model joining the RGMII ports of num_chips_p test chips with a
// static swap or ring topology and per-link latency.
module bp_rgmii_multi_link
    import bp_rgmii_multi_link_pkg::*;
#(
    parameter int unsigned num_chips_p   = 2,
    parameter int unsigned topology_p    = 0,
    parameter int unsigned delay_p       = 1,
    parameter int unsigned count_width_p = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [4*num_chips_p-1:0]             tx_data_i,
    input  logic [num_chips_p-1:0]               tx_ctl_i,
    input  logic [num_chips_p-1:0]               link_en_i,
    output logic [num_chips_p-1:0]               rx_clk_o,
    output logic [4*num_chips_p-1:0]             rx_data_o,
    output logic [num_chips_p-1:0]               rx_ctl_o,
    output logic [count_width_p*num_chips_p-1:0] frame_count_o,
    output logic [count_width_p*num_chips_p-1:0] drop_count_o
);

    if (topology_p == e_topo_swap && (num_chips_p % 2) != 0) begin : gen_bad_swap
        $error("bp_rgmii_multi_link: swap topology needs an even num_chips_p");
    end
    if (delay_p == 0) begin : gen_bad_delay
        $error("bp_rgmii_multi_link: delay_p must be at least 1");
    end

    logic [num_chips_p-1:0]      lane_ctl;
    logic [num_chips_p-1:0][3:0] lane_data;

    assign rx_clk_o = {num_chips_p{clk_i}};

    for (genvar i = 0; i < num_chips_p; i++) begin : gen_lane
        localparam int unsigned src = bp_rgmii_src_of(i, num_chips_p, topology_p);

        bp_rgmii_link_lane #(
            .delay_p      (delay_p),
            .count_width_p(count_width_p)
        ) u_lane (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .tx_data_i    (tx_data_i[4*i +: 4]),
            .tx_ctl_i     (tx_ctl_i[i]),
            .link_en_i    (link_en_i[i]),
            .rx_data_o    (lane_data[i]),
            .rx_ctl_o     (lane_ctl[i]),
            .frame_count_o(frame_count_o[count_width_p*i +: count_width_p]),
            .drop_count_o (drop_count_o[count_width_p*i +: count_width_p])
        );

        assign rx_ctl_o[i]        = lane_ctl[src];
        assign rx_data_o[4*i +: 4] = lane_data[src];
    end

endmodule

// File: tb/tb_bp_rgmii_multi_link.sv
// Directed bench: swap/delay-3, ring/saturating-counter and swap/delay-2
// instances exercised one after another with a shared reset.
module tb_bp_rgmii_multi_link;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // A: swap, N=2, delay 3
    logic [7:0]  a_tx_data = '0;
    logic [1:0]  a_tx_ctl  = '0;
    logic [1:0]  a_en      = 2'b11;
    logic [1:0]  a_rx_clk, a_rx_ctl;
    logic [7:0]  a_rx_data;
    logic [31:0] a_fc, a_dc;

    // B: ring, N=4, delay 1, 2-bit counters
    logic [15:0] b_tx_data = '0;
    logic [3:0]  b_tx_ctl  = '0;
    logic [3:0]  b_en      = 4'hF;
    logic [3:0]  b_rx_clk, b_rx_ctl;
    logic [15:0] b_rx_data;
    logic [7:0]  b_fc, b_dc;

    // C: swap, N=2, delay 2
    logic [7:0]  c_tx_data = '0;
    logic [1:0]  c_tx_ctl  = '0;
    logic [1:0]  c_en      = 2'b11;
    logic [1:0]  c_rx_clk, c_rx_ctl;
    logic [7:0]  c_rx_data;
    logic [31:0] c_fc, c_dc;

    bp_rgmii_multi_link #(.num_chips_p(2), .topology_p(0), .delay_p(3), .count_width_p(16)) dut_a (
        .clk_i(clk), .reset_i(reset), .tx_data_i(a_tx_data), .tx_ctl_i(a_tx_ctl),
        .link_en_i(a_en), .rx_clk_o(a_rx_clk), .rx_data_o(a_rx_data), .rx_ctl_o(a_rx_ctl),
        .frame_count_o(a_fc), .drop_count_o(a_dc)
    );

    bp_rgmii_multi_link #(.num_chips_p(4), .topology_p(1), .delay_p(1), .count_width_p(2)) dut_b (
        .clk_i(clk), .reset_i(reset), .tx_data_i(b_tx_data), .tx_ctl_i(b_tx_ctl),
        .link_en_i(b_en), .rx_clk_o(b_rx_clk), .rx_data_o(b_rx_data), .rx_ctl_o(b_rx_ctl),
        .frame_count_o(b_fc), .drop_count_o(b_dc)
    );

    bp_rgmii_multi_link #(.num_chips_p(2), .topology_p(0), .delay_p(2), .count_width_p(16)) dut_c (
        .clk_i(clk), .reset_i(reset), .tx_data_i(c_tx_data), .tx_ctl_i(c_tx_ctl),
        .link_en_i(c_en), .rx_clk_o(c_rx_clk), .rx_data_o(c_rx_data), .rx_ctl_o(c_rx_ctl),
        .frame_count_o(c_fc), .drop_count_o(c_dc)
    );

    // Beats delivered to chip 1 of each instance, sampled mid-cycle.
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] qc[$];
    always @(negedge clk) begin
        if (a_rx_ctl[1]) qa.push_back(a_rx_data[7:4]);
        if (b_rx_ctl[1]) qb.push_back(b_rx_data[7:4]);
        if (c_rx_ctl[1]) qc.push_back(c_rx_data[7:4]);
    end

    typedef struct {
        logic       ctl;
        logic [3:0] data;
        logic       exp_ctl;
        logic [3:0] exp_data;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        qa.delete();
        qb.delete();
        qc.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // chip0 -> chip1, delay 3: output at row k is the gated beat of row k-2
        tbl[0] = '{1'b0, 4'hF, 1'b0, 4'h0};
        tbl[1] = '{1'b1, 4'h1, 1'b0, 4'h0};
        tbl[2] = '{1'b1, 4'h2, 1'b0, 4'h0};
        tbl[3] = '{1'b1, 4'h3, 1'b1, 4'h1};
        tbl[4] = '{1'b1, 4'h4, 1'b1, 4'h2};
        tbl[5] = '{1'b1, 4'h5, 1'b1, 4'h3};
        tbl[6] = '{1'b0, 4'hA, 1'b1, 4'h4};
        tbl[7] = '{1'b0, 4'h0, 1'b1, 4'h5};
        tbl[8] = '{1'b0, 4'h0, 1'b0, 4'h0};
        tbl[9] = '{1'b0, 4'h0, 1'b0, 4'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_a_rx_ctl", 32'(a_rx_ctl), 32'h0);
        check("reset_a_rx_data", 32'(a_rx_data), 32'h0);
        check("reset_a_fc", a_fc, 32'h0);
        check("reset_b_rx_ctl", 32'(b_rx_ctl), 32'h0);
        check("reset_b_fc", 32'(b_fc), 32'h0);
        check("reset_c_dc", c_dc, 32'h0);
        check("rx_clk_hi", 32'({a_rx_clk, b_rx_clk, c_rx_clk}), 32'h0);

        // Swap latency table
        for (int k = 0; k < 10; k++) begin
            a_tx_ctl[0]     = tbl[k].ctl;
            a_tx_data[3:0]  = tbl[k].data;
            cyc();
            check($sformatf("swap_ctl1[%0d]", k), 32'(a_rx_ctl[1]), 32'(tbl[k].exp_ctl));
            check($sformatf("swap_data1[%0d]", k), 32'(a_rx_data[7:4]), 32'(tbl[k].exp_data));
            check($sformatf("swap_ctl0[%0d]", k), 32'(a_rx_ctl[0]), 32'h0);
        end
        check("swap_fc", a_fc, 32'h0000_0001);
        check("swap_dc", a_dc, 32'h0);

        // Disabled at frame start: whole frame dropped
        do_reset();
        a_en = 2'b10;
        for (int k = 0; k < 4; k++) begin
            a_tx_ctl[0] = 1'b1;
            a_tx_data[3:0] = 4'h7;
            cyc();
        end
        a_tx_ctl[0] = 1'b0;
        repeat (5) cyc();
        check("drop_rx_beats", 32'(qa.size()), 32'd0);
        check("drop_dc", a_dc, 32'h0000_0001);
        check("drop_fc", a_fc, 32'h0);

        // Enable falls mid-frame: frame completes, next frame dropped
        do_reset();
        a_en = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            a_tx_ctl[0] = 1'b1;
            a_tx_data[3:0] = 4'(k);
            if (k == 2) a_en[0] = 1'b0;
            cyc();
        end
        a_tx_ctl[0] = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            a_tx_ctl[0] = 1'b1;
            a_tx_data[3:0] = 4'hE;
            cyc();
        end
        a_tx_ctl[0] = 1'b0;
        repeat (5) cyc();
        check("midfrm_rx_beats", 32'(qa.size()), 32'd6);
        for (int k = 0; k < qa.size() && k < 6; k++) begin
            check($sformatf("midfrm_beat[%0d]", k), 32'(qa[k]), 32'(k + 1));
        end
        check("midfrm_fc", a_fc, 32'h0000_0001);
        check("midfrm_dc", a_dc, 32'h0000_0001);
        a_en = 2'b11;

        // Ring: all chips send nibble i for two beats
        do_reset();
        b_tx_ctl  = 4'hF;
        b_tx_data = 16'h3210;
        cyc();
        check("ring_ctl_b1", 32'(b_rx_ctl), 32'hF);
        check("ring_data_b1", 32'(b_rx_data), 32'h2103);
        cyc();
        check("ring_ctl_b2", 32'(b_rx_ctl), 32'hF);
        check("ring_data_b2", 32'(b_rx_data), 32'h2103);
        b_tx_ctl  = 4'h0;
        b_tx_data = 16'hFFFF;
        cyc();
        check("ring_ctl_end", 32'(b_rx_ctl), 32'h0);
        check("ring_data_end", 32'(b_rx_data), 32'h0);
        cyc();
        check("ring_fc", 32'(b_fc), 32'h55);
        check("ring_dc", 32'(b_dc), 32'h0);

        // 2-bit counter saturates while every frame is still delivered
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            b_tx_ctl[0] = 1'b1;
            b_tx_data[3:0] = 4'(k);
            cyc();
            b_tx_ctl[0] = 1'b0;
            cyc();
        end
        repeat (3) cyc();
        check("sat_fc", 32'(b_fc), 32'h03);
        check("sat_rx_beats", 32'(qb.size()), 32'd5);
        for (int k = 0; k < qb.size() && k < 5; k++) begin
            check($sformatf("sat_beat[%0d]", k), 32'(qb[k]), 32'(k + 1));
        end

        // Reset pulsed at beat 3 of an 8-beat frame, delay 2
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            c_tx_ctl[0] = 1'b1;
            c_tx_data[3:0] = 4'(k);
            cyc();
        end
        check("rst_pre_ctl", 32'(c_rx_ctl[1]), 32'h1);
        check("rst_pre_data", 32'(c_rx_data[7:4]), 32'h1);
        c_tx_data[3:0] = 4'h3;
        reset = 1'b1;
        #1;
        check("rst_async_ctl", 32'(c_rx_ctl), 32'h0);
        check("rst_async_data", 32'(c_rx_data), 32'h0);
        check("rst_async_fc", c_fc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        qc.delete();
        for (int k = 4; k <= 8; k++) begin
            c_tx_data[3:0] = 4'(k);
            cyc();
        end
        c_tx_ctl[0] = 1'b0;
        repeat (4) cyc();
        check("rst_fc", c_fc, 32'h0000_0001);
        check("rst_dc", c_dc, 32'h0);
        check("rst_rx_beats", 32'(qc.size()), 32'd5);
        for (int k = 0; k < qc.size() && k < 5; k++) begin
            check($sformatf("rst_beat[%0d]", k), 32'(qc[k]), 32'(k + 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
